// File: rtl/strobe_sampler_pkg.sv
// strobe_sampler_pkg: shared definitions for the strobe sampler.
//   - ser_state_e : serialiser FSM states (IDLE=0, SEND=1)
//   - helpers     : bytes-per-sample, byte-index width, parameter legality
package strobe_sampler_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_e;

  function automatic int unsigned sample_nbytes(int unsigned sample_w);
    return sample_w / BYTE_W;
  endfunction

  // A single-byte sample still needs a 1-bit index register.
  function automatic int unsigned idx_width(int unsigned nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit sample_w_ok(int unsigned sample_w);
    return (sample_w >= 8) && (sample_w <= 64) && ((sample_w % BYTE_W) == 0);
  endfunction

endpackage

// File: rtl/strobe_sampler_if.sv
// strobe_sampler_if: valid/ready byte stream toward the host link.
//   byte_data  : current byte (driven by master)
//   byte_valid : byte_data valid (driven by master)
//   byte_ready : consumer accepts byte_data (driven by slave)
interface strobe_sampler_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/strobe_sampler_sample_fifo.sv
// strobe_sampler_sample_fifo: synchronous pointer-based sample FIFO.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_cg             : clock-gate enable; when 0 nothing updates
//   i_push, i_data   : write request and data
//   i_pop            : read request; o_data shows the head entry
//   o_level          : entry count; o_full / o_empty status
module strobe_sampler_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra MSB distinguishes full from empty when the indices match.
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_level = r_wr - r_rd;
  assign o_full  = (o_level == (AW + 1)'(DEPTH));
  assign o_empty = (r_wr == r_rd);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  assign w_wr_en = i_cg && i_push && !o_full;
  assign w_rd_en = i_cg && i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + 1'b1;
      if (w_rd_en) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/strobe_sampler.sv
// strobe_sampler: captures a sample on each strobe into a FIFO and streams
// queued samples LSB-byte-first over a valid/ready byte interface.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_cg           : clock-gate enable; when 0 all state holds
//   i_enable       : when 0 strobes are ignored
//   i_strobe       : single-cycle capture strobe; i_sample is the data
//   i_clearDrops   : clears o_overflow / o_dropCount (a same-cycle drop wins)
//   o_stream       : byte stream (master side)
//   o_fifoLevel    : queued samples, excluding the one being serialised
//   o_overflow     : sticky drop flag; o_dropCount saturating drop count
module strobe_sampler
  import strobe_sampler_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_cg,
  input  logic                        i_enable,
  input  logic                        i_strobe,
  input  logic [SAMPLE_W-1:0]         i_sample,
  input  logic                        i_clearDrops,
  strobe_sampler_if.master            o_stream,
  output logic [$clog2(FIFO_DEPTH):0] o_fifoLevel,
  output logic                        o_overflow,
  output logic [DROP_W-1:0]           o_dropCount
);

  localparam int unsigned NBYTES = sample_nbytes(SAMPLE_W);
  localparam int unsigned IDX_W  = idx_width(NBYTES);

  if (!sample_w_ok(SAMPLE_W)) begin : g_bad_sample_w
    $error("strobe_sampler: SAMPLE_W must be a multiple of 8 in 8..64");
  end
  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 || FIFO_DEPTH > 32) begin : g_bad_depth
    $error("strobe_sampler: FIFO_DEPTH must be a power of 2 in 2..32");
  end

  ser_state_e            r_state;
  logic [SAMPLE_W-1:0]   r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;
  logic                  r_overflow;
  logic [DROP_W-1:0]     r_dropCount;

  logic                  w_strobe;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_hs;
  logic                  w_last;
  logic                  w_pop;
  logic [SAMPLE_W-1:0]   w_head;
  logic                  w_full;
  logic                  w_empty;

  // Full is judged at the start of the cycle, so a same-cycle pop never
  // rescues a strobe that arrives while the FIFO is full.
  assign w_strobe = i_cg && i_enable && i_strobe;
  assign w_push   = w_strobe && !w_full;
  assign w_drop   = w_strobe && w_full;

  assign w_hs   = i_cg && r_valid && o_stream.byte_ready;
  assign w_last = (r_idx == IDX_W'(NBYTES - 1));
  // Pop either starts a transfer from IDLE or chains the next sample
  // straight after the last byte, avoiding a bubble.
  assign w_pop  = i_cg && !w_empty &&
                  ((r_state == StIdle) || (w_hs && w_last));

  strobe_sampler_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_cg    (i_cg),
    .i_push  (w_push),
    .i_data  (i_sample),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (o_fifoLevel),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (i_cg) begin
      unique case (r_state)
        StIdle: begin
          if (!w_empty) begin
            r_shift <= w_head;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_state <= StSend;
          end
        end
        StSend: begin
          if (o_stream.byte_ready) begin
            if (!w_last) begin
              r_shift <= r_shift >> 8;
              r_idx   <= r_idx + IDX_W'(1);
            end else if (!w_empty) begin
              r_shift <= w_head;
              r_idx   <= '0;
            end else begin
              r_valid <= 1'b0;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else if (i_cg) begin
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (i_clearDrops) begin
          r_dropCount <= DROP_W'(1);
        end else if (r_dropCount != {DROP_W{1'b1}}) begin
          r_dropCount <= r_dropCount + DROP_W'(1);
        end
      end else if (i_clearDrops) begin
        r_overflow  <= 1'b0;
        r_dropCount <= '0;
      end
    end
  end

  assign o_stream.byte_data  = r_shift[7:0];
  assign o_stream.byte_valid = r_valid;
  assign o_overflow          = r_overflow;
  assign o_dropCount         = r_dropCount;

endmodule

// File: tb/tb_strobe_sampler.sv
module tb_strobe_sampler;

  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 2;
  localparam int unsigned NB    = SW / 8;
  localparam int          MAXC  = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, cg, en, stb, clr, rdy;
  logic [SW-1:0] smp;
  logic [2:0]    lvl;
  logic          ovf;
  logic [DW-1:0] cnt;

  strobe_sampler_if u_if ();
  assign u_if.byte_ready = rdy;

  strobe_sampler #(
    .SAMPLE_W   (SW),
    .FIFO_DEPTH (DEPTH),
    .DROP_W     (DW)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cg         (cg),
    .i_enable     (en),
    .i_strobe     (stb),
    .i_sample     (smp),
    .i_clearDrops (clr),
    .o_stream     (u_if),
    .o_fifoLevel  (lvl),
    .o_overflow   (ovf),
    .o_dropCount  (cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: queue of waiting samples plus the sample in flight.
  logic [SW-1:0] mq [$];
  bit            m_busy;
  logic [SW-1:0] m_cur;
  int            m_idx;
  bit            m_ovf;
  int            m_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int lvl0;
    bit strobe;
    if (rst) begin
      mq.delete();
      m_busy = 0; m_cur = '0; m_idx = 0; m_ovf = 0; m_cnt = 0;
    end else if (cg) begin
      lvl0   = mq.size();
      strobe = en && stb;
      if (!m_busy) begin
        if (lvl0 > 0) begin
          m_cur = mq.pop_front(); m_idx = 0; m_busy = 1;
        end
      end else if (rdy) begin
        if (m_idx < NB - 1) m_idx++;
        else if (lvl0 > 0) begin m_cur = mq.pop_front(); m_idx = 0; end
        else m_busy = 0;
      end
      if (strobe && lvl0 < DEPTH) mq.push_back(smp);
      if (strobe && lvl0 == DEPTH) begin
        m_ovf = 1;
        if (clr) m_cnt = 1;
        else if (m_cnt < MAXC) m_cnt++;
      end else if (clr) begin
        m_ovf = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic compare_model();
    logic [SW-1:0] sh;
    chk("valid", u_if.byte_valid, m_busy);
    if (m_busy) begin
      sh = m_cur >> (8 * m_idx);
      chk("byte", u_if.byte_data, sh[7:0]);
    end
    chk("level", lvl, mq.size());
    chk("overflow", ovf, m_ovf);
    chk("dropCount", cnt, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 0; cg = 1; en = 1; stb = 0; clr = 0; rdy = 1; smp = '0;
  endtask

  logic [15:0] b2b_s [3] = '{16'h0102, 16'h0304, 16'h0506};
  logic [7:0]  b2b_b [6] = '{8'h02, 8'h01, 8'h04, 8'h03, 8'h06, 8'h05};
  logic [7:0]  got [$];

  initial begin
    idle_inputs();
    rst = 1;
    @(negedge clk);
    step(); step();
    chk("rst_valid", u_if.byte_valid, 1'b0);
    chk("rst_byte", u_if.byte_data, 8'h00);
    chk("rst_level", lvl, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cnt", cnt, 2'd0);
    idle_inputs();

    // Single sample: byte0 at t+2, byte1 at t+3, then idle.
    stb = 1; smp = 16'hA55A; step();
    stb = 0; step();
    chk("single_b0_valid", u_if.byte_valid, 1'b1);
    chk("single_b0", u_if.byte_data, 8'h5A);
    step();
    chk("single_b1", u_if.byte_data, 8'hA5);
    step();
    chk("single_done", u_if.byte_valid, 1'b0);

    // Back-to-back strobes stream without bubbles.
    for (int i = 0; i < 8; i++) begin
      stb = (i < 3);
      if (i < 3) smp = b2b_s[i];
      step();
      if (i >= 1 && i <= 6) begin
        chk("b2b_valid", u_if.byte_valid, 1'b1);
        chk("b2b_byte", u_if.byte_data, b2b_b[i-1]);
      end
      if (i == 7) chk("b2b_done", u_if.byte_valid, 1'b0);
    end
    chk("b2b_drops", cnt, 2'd0);

    // Overflow with consumer stalled, then drain in order.
    rdy = 0;
    for (int k = 0; k < 7; k++) begin
      stb = 1; smp = {8'(8'hC0 + k), 8'(8'h30 + k)}; step();
    end
    stb = 0;
    chk("ovf_level", lvl, 3'd4);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_cnt", cnt, 2'd2);
    rdy = 1;
    got.delete();
    for (int k = 0; k < 30; k++) begin
      if (u_if.byte_valid) got.push_back(u_if.byte_data);
      step();
    end
    chk("drain_count", got.size(), 10);
    for (int k = 0; k < 5 && got.size() == 10; k++) begin
      chk("drain_lo", got[2*k],   8'(8'h30 + k));
      chk("drain_hi", got[2*k+1], 8'(8'hC0 + k));
    end
    clr = 1; step(); clr = 0;
    chk("clear_ovf", ovf, 1'b0);
    chk("clear_cnt", cnt, 2'd0);

    // Saturation, then clear racing a drop.
    rdy = 0;
    for (int k = 0; k < 10; k++) begin
      stb = 1; smp = 16'($urandom); step();
    end
    chk("sat_cnt", cnt, 2'd3);
    chk("sat_level", lvl, 3'd4);
    clr = 1; step();
    chk("clrdrop_cnt", cnt, 2'd1);
    chk("clrdrop_ovf", ovf, 1'b1);
    stb = 0; step(); clr = 0;
    chk("clr_cnt", cnt, 2'd0);
    rdy = 1;
    for (int k = 0; k < 30; k++) step();

    // Enable low: strobes ignored.
    en = 0; stb = 1;
    for (int k = 0; k < 3; k++) step();
    chk("en_level", lvl, 3'd0);
    chk("en_valid", u_if.byte_valid, 1'b0);
    en = 1; smp = 16'hCAFE; step();
    stb = 0; step();
    chk("cg_b0", u_if.byte_data, 8'hFE);
    // Gate off mid-transfer: output must hold, strobes ignored.
    cg = 0; stb = 1; smp = 16'h7777;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("cg_hold_valid", u_if.byte_valid, 1'b1);
      chk("cg_hold_byte", u_if.byte_data, 8'hFE);
    end
    cg = 1; stb = 0; step();
    chk("cg_b1", u_if.byte_data, 8'hCA);
    step();
    chk("cg_done", u_if.byte_valid, 1'b0);

    // Reset mid-transfer discards the partial sample.
    stb = 1; smp = 16'hBEEF; step();
    stb = 0; step();
    chk("rst_mid_b0", u_if.byte_data, 8'hEF);
    step();
    chk("rst_mid_b1", u_if.byte_data, 8'hBE);
    rst = 1; step(); rst = 0;
    chk("rst_mid_valid", u_if.byte_valid, 1'b0);
    chk("rst_mid_level", lvl, 3'd0);
    chk("rst_mid_cnt", cnt, 2'd0);
    stb = 1; smp = 16'h1234; step();
    stb = 0; step();
    chk("post_rst_b0", u_if.byte_data, 8'h34);
    step();
    chk("post_rst_b1", u_if.byte_data, 8'h12);
    step();
    chk("post_rst_done", u_if.byte_valid, 1'b0);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      cg  = ($urandom_range(0, 9) != 0);
      en  = ($urandom_range(0, 9) != 0);
      stb = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      smp = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/strobe_sampler.md
Name: strobe_sampler

Overview:
- Downstream consumer of the jittered strobe generator.
- On each strobe pulse it captures a parallel sample into a small synchronous FIFO.
- It serialises queued samples LSB-byte-first onto a valid/ready byte stream for the host link.
- Drops on full are counted and flagged, so host software can judge sampling integrity.

Parameters:
SAMPLE_W, 16, sample width in bits; must be a multiple of 8, range 8..64.
FIFO_DEPTH, 4, sample FIFO entries; power of 2, range 2..32.
DROP_W, 8, width of saturating drop counter.

Ports:
i_clk  input  1  clock; all state changes on the rising edge.
i_rst  input  1  reset, synchronous, active-high.
i_cg  input  1  clock-gate enable; when 0, all state holds.
i_enable  input  1  when 0, strobes are ignored (no push, no drop count).
i_strobe  input  1  single-cycle sample strobe from the strobe generator.
i_sample  input  SAMPLE_W  data captured on strobe.
i_clearDrops  input  1  clears o_overflow and o_dropCount.
o_byte  output  8  current output byte.
o_byteValid  output  1  o_byte valid.
i_byteReady  input  1  consumer accepts o_byte.
o_fifoLevel  output  $clog2(FIFO_DEPTH)+1  samples queued, excluding the one being serialised.
o_overflow  output  1  sticky: at least one strobe was dropped.
o_dropCount  output  DROP_W  saturating count of dropped strobes.

Behaviour:
- Reset (i_rst=1 at an edge, regardless of i_cg):
  - FIFO empty, serialiser IDLE.
  - o_byteValid=0, o_byte=0, o_fifoLevel=0, o_overflow=0, o_dropCount=0.
  - A partially sent sample is discarded; no completion is required.
- Clock gating: with i_cg=0, no register updates. o_byteValid and o_byte stay stable. A handshake completes only when i_cg && o_byteValid && i_byteReady.
- Push: strobe event = i_cg && i_enable && i_strobe.
  - Level < FIFO_DEPTH at start of cycle: write i_sample at the edge.
  - Level == FIFO_DEPTH at start of cycle: drop the sample, even if a pop occurs in the same cycle. Set o_overflow=1 and increment o_dropCount, saturating at 2^DROP_W-1.
- i_clearDrops at an edge clears both drop indicators. If a drop happens in the same cycle, the drop wins: o_overflow=1, o_dropCount=1.
- Serialiser FSM, NBYTES = SAMPLE_W/8, byte index counter 0..NBYTES-1:
  - IDLE: if FIFO non-empty, pop head into shift register, index=0, go SEND. o_byteValid=1 from the next cycle.
  - SEND: o_byte = shift register bits [7:0]. On handshake:
    - index < NBYTES-1: shift right 8, index++.
    - last byte, FIFO non-empty: pop and load the next sample with no bubble; o_byteValid stays 1.
    - last byte, FIFO empty: go IDLE, o_byteValid=0.
- Latency: strobe in cycle t, then FIFO write at end of t, load at end of t+1, byte0 valid in cycle t+2 (consumer ready, i_cg=1).
- Simultaneous push and pop with level < FIFO_DEPTH: level unchanged, both succeed.
- Pointer arithmetic wraps modulo FIFO_DEPTH. Level is computed from pointers with one extra MSB.
- o_byte is registered: it changes only on load or shift, never combinationally from i_byteReady.
- Holding i_byteReady=0 forever: FIFO fills, then further strobes drop. No deadlock; draining resumes on ready.

Decomposition:
- Shared header: NBYTES derivation, FSM state encodings (IDLE=0, SEND=1), and parameter legality checks (SAMPLE_W%8==0, FIFO_DEPTH power of 2).
- One natural sub-module: sample_fifo, a synchronous pointer-based FIFO with push/pop/level/full/empty, i_cg gated and synchronously reset.
- Serialiser FSM and drop accounting live in the top.

Test Plan:
- Single sample: SAMPLE_W=16, i_sample=16'hA55A, one strobe at t, ready=1 → byte 8'h5A valid at t+2, 8'hA5 at t+3, then o_byteValid=0.
- Back-to-back: strobes every cycle ×3 with 16'h0102, 16'h0304, 16'h0506, ready=1 → bytes 02,01,04,03,06,05 on consecutive cycles, no bubbles; o_dropCount=0.
- Overflow: ready=0, 7 strobes, FIFO_DEPTH=4 → first sample enters the shift register; level=4; 2 drops, o_overflow=1, o_dropCount=2. Drain → exactly 5 samples out, in order.
- Saturation/clear: DROP_W=2, FIFO full, 5 drops → o_dropCount=3. Pulse i_clearDrops with a concurrent drop → o_dropCount=1, o_overflow=1.
- Gating/enable: i_enable=0 strobes → level stays 0. i_cg=0 mid-SEND with ready=1 → o_byte stable, no byte lost or repeated when i_cg returns.
- Reset mid-transfer: after byte0 of 16'hBEEF is accepted, assert i_rst one cycle → o_byteValid=0, level=0, counters 0. Next strobe with 16'h1234 → outputs 34,12 only.
